fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of decode. It drives pc_decode, instr_decode and valid_decode into decode.
- Owns the program counter. Issues in-order requests to instruction memory over a request/grant/rvalid handshake.
- Buffers returned instructions so that decode stalls never drop data.
- Accepts redirects (branches, jumps, traps) from execute and squashes all wrong-path fetches.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/fetch.sv | 82 ++++++++
 tb/tb_fetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the {pc, instr} entry type for the fetch stage
package fetch_pkg;
    localparam int REG_DATA_WIDTH = 32;
    localparam logic [REG_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int FETCH_DEPTH = 2;
    typedef struct packed {
        logic [REG_DATA_WIDTH-1:0] pc;
        logic [REG_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular FIFO with flush, count and full/empty flags
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty && !flush));
endmodule

// File: rtl/fetch.sv
// fetch: PC owner, credit-limited in-order imem requester and buffered feed into decode
module fetch
    import fetch_pkg::*;
#(
    parameter logic [REG_DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req,
    output logic [REG_DATA_WIDTH-1:0] imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [REG_DATA_WIDTH-1:0] imem_rdata,
    input  logic                      redirect,
    input  logic [REG_DATA_WIDTH-1:0] redirect_pc,
    input  logic                      stall_decode,
    output logic [REG_DATA_WIDTH-1:0] pc_decode,
    output logic [REG_DATA_WIDTH-1:0] instr_decode,
    output logic                      valid_decode
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [REG_DATA_WIDTH-1:0] pc_q, tag_pc;
    logic [CW-1:0] outstanding, discard_cnt, fifo_count, tag_count;
    logic credit_ok, gnt_fire, live_rsp, bypass, fifo_push, fifo_pop;
    logic fifo_full, fifo_empty, tag_full, tag_empty;
    fetch_entry_t fifo_in, fifo_head;
    assign credit_ok = (outstanding + fifo_count) < CW'(DEPTH);
    assign imem_req = rst_n && credit_ok && !redirect;
    assign imem_addr = pc_q;
    assign gnt_fire = imem_req && imem_gnt;
    assign live_rsp = imem_rvalid && discard_cnt == '0 && !redirect;
    // an empty, unstalled FIFO lets the response go straight to decode
    assign bypass = live_rsp && fifo_empty && !stall_decode;
    assign fifo_push = live_rsp && !bypass;
    assign fifo_pop = !fifo_empty && !stall_decode && !redirect;
    assign fifo_in = '{pc: tag_pc, instr: imem_rdata};
    fetch_fifo #(.WIDTH(REG_DATA_WIDTH), .DEPTH(DEPTH)) u_tags (
        .clk(clk), .rst_n(rst_n), .push(gnt_fire), .pop(live_rsp), .flush(redirect),
        .wdata(pc_q), .rdata(tag_pc), .count(tag_count), .full(tag_full), .empty(tag_empty)
    );
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(fifo_push), .pop(fifo_pop), .flush(redirect),
        .wdata(fifo_in), .rdata(fifo_head), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            pc_decode <= '0;
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(gnt_fire) - CW'(imem_rvalid);
            if (redirect) begin
                pc_q <= redirect_pc;
                // everything still in flight after this edge belongs to the wrong path
                discard_cnt <= outstanding - CW'(imem_rvalid);
                valid_decode <= 1'b0;
                instr_decode <= NOP_INSTR;
            end else begin
                if (gnt_fire) pc_q <= pc_q + 32'd4;
                if (imem_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
                if (!stall_decode) begin
                    valid_decode <= fifo_pop || bypass;
                    if (fifo_pop || bypass) begin
                        pc_decode <= fifo_pop ? fifo_head.pc : tag_pc;
                        instr_decode <= fifo_pop ? fifo_head.instr : imem_rdata;
                    end
                end
            end
        end
    end
    assert property (@(posedge clk) disable iff (!rst_n) outstanding <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) imem_req |-> imem_addr[1:0] == 2'b00);
    assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> outstanding != '0);
    assert property (@(posedge clk) disable iff (!rst_n) tag_count <= outstanding);
    assert property (@(posedge clk) disable iff (!rst_n) !(gnt_fire && tag_full));
    assert property (@(posedge clk) disable iff (!rst_n) !(live_rsp && tag_empty));
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full && !fifo_pop));
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed vector table plus corner sequences against an in-order imem model
module tb_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic imem_req, imem_gnt, imem_rvalid, redirect, stall_decode, valid_decode;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, pc_decode, instr_decode;
    logic mem_hold;
    logic [31:0] mq[$];
    int checks = 0;
    int failures = 0;

    fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall_decode(stall_decode),
        .pc_decode(pc_decode), .instr_decode(instr_decode), .valid_decode(valid_decode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic stall, redir, hold;
        logic [31:0] rpc;
        logic req;
        logic [31:0] addr;
        logic valid;
        logic [31:0] pc, instr;
    } vec_t;
    vec_t v[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // one clock; the memory answers in order, one cycle after grant at the earliest
    task automatic step();
        logic fire, took;
        logic [31:0] faddr;
        #1;
        fire = imem_req && imem_gnt;
        faddr = imem_addr;
        took = imem_rvalid;
        @(posedge clk);
        #1;
        if (took) void'(mq.pop_front());
        if (fire) mq.push_back(faddr);
        imem_rvalid = mq.size() != 0 && !mem_hold;
        imem_rdata = imem_rvalid ? (mq[0] ^ 32'hA5) : 32'h0;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, {31'b0, valid_decode}, {31'b0, valid});
        chk({tag, ".pc"}, pc_decode, pc);
        chk({tag, ".instr"}, instr_decode, instr);
    endtask

    initial begin
        v[0]  = '{0, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h13};
        v[1]  = '{0, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0,   32'hA5};
        v[2]  = '{0, 0, 0, 32'h0,   1, 32'hC,   1, 32'h4,   32'hA1};
        v[3]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h8,   32'hAD};
        v[4]  = '{1, 0, 0, 32'h0,   0, 32'h14,  1, 32'h8,   32'hAD};
        v[5]  = '{1, 0, 0, 32'h0,   0, 32'h14,  1, 32'h8,   32'hAD};
        v[6]  = '{1, 0, 0, 32'h0,   0, 32'h14,  1, 32'h8,   32'hAD};
        v[7]  = '{1, 0, 0, 32'h0,   0, 32'h14,  1, 32'h8,   32'hAD};
        v[8]  = '{1, 0, 0, 32'h0,   0, 32'h14,  1, 32'h8,   32'hAD};
        v[9]  = '{0, 0, 0, 32'h0,   1, 32'h14,  1, 32'hC,   32'hA9};
        v[10] = '{0, 0, 0, 32'h0,   1, 32'h18,  1, 32'h10,  32'hB5};
        v[11] = '{0, 0, 0, 32'h0,   1, 32'h1C,  1, 32'h14,  32'hB1};
        v[12] = '{0, 0, 1, 32'h0,   1, 32'h20,  1, 32'h18,  32'hBD};
        v[13] = '{0, 0, 1, 32'h0,   0, 32'h24,  0, 32'h18,  32'hBD};
        v[14] = '{0, 1, 1, 32'h100, 0, 32'h100, 0, 32'h18,  32'h13};
        v[15] = '{0, 0, 0, 32'h0,   0, 32'h100, 0, 32'h18,  32'h13};
        v[16] = '{0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h18,  32'h13};
        v[17] = '{0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h18,  32'h13};
        v[18] = '{0, 0, 0, 32'h0,   1, 32'h108, 1, 32'h100, 32'h1A5};

        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall_decode = 1'b0;
        mem_hold = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h13);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_out("release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h13);

        for (int i = 0; i < 19; i++) begin
            stall_decode = v[i].stall;
            redirect = v[i].redir;
            redirect_pc = v[i].rpc;
            mem_hold = v[i].hold;
            step();
            chk_out($sformatf("vec%0d", i), v[i].req, v[i].addr, v[i].valid, v[i].pc, v[i].instr);
        end

        // redirect while stalled with a full FIFO
        stall_decode = 1'b1;
        step();
        chk("fill.pc", pc_decode, 32'h100);
        step();
        chk("fill.req", {31'b0, imem_req}, 32'h0);
        chk("fill.count", {30'b0, dut.fifo_count}, 32'h2);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        chk("stallredir.valid", {31'b0, valid_decode}, 32'h0);
        chk("stallredir.instr", instr_decode, 32'h13);
        redirect = 1'b0;
        #1;
        chk("stallredir.count", {30'b0, dut.fifo_count}, 32'h0);
        chk("stallredir.req", {31'b0, imem_req}, 32'h1);
        chk("stallredir.addr", imem_addr, 32'h200);
        stall_decode = 1'b0;
        step();
        chk("stallredir.gap", {31'b0, valid_decode}, 32'h0);
        step();
        chk_out("stallredir.first", 1'b1, 32'h208, 1'b1, 32'h200, 32'h2A5);

        // grant withheld for four cycles
        imem_gnt = 1'b0;
        step();
        chk_out("nognt0", 1'b1, 32'h208, 1'b1, 32'h204, 32'h2A1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("nognt%0d.addr", i), imem_addr, 32'h208);
            chk($sformatf("nognt%0d.req", i), {31'b0, imem_req}, 32'h1);
            chk($sformatf("nognt%0d.valid", i), {31'b0, valid_decode}, 32'h0);
        end
        imem_gnt = 1'b1;
        step();
        chk("gnt.addr", imem_addr, 32'h20C);
        step();
        chk_out("gnt.resume", 1'b1, 32'h210, 1'b1, 32'h208, 32'h2AD);

        // wrap past the top of the address space, with a response landing in the redirect cycle
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap.valid", {31'b0, valid_decode}, 32'h0);
        redirect = 1'b0;
        #1;
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap.addr1", imem_addr, 32'h0);
        chk("wrap.gap", {31'b0, valid_decode}, 32'h0);
        step();
        chk_out("wrap.top", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FF59);
        step();
        chk_out("wrap.zero", 1'b1, 32'h8, 1'b1, 32'h0, 32'hA5);

        // asynchronous reset mid-stream, between clock edges
        #3 rst_n = 1'b0;
        mq.delete();
        imem_rvalid = 1'b0;
        #1;
        chk_out("areset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h13);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_out("rerelease", 1'b1, 32'h0, 1'b0, 32'h0, 32'h13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
